tcu_reset_seq: RTL and testbench
================================

// Module: tcu_reset_seq
// PURPOSE
//  Multi-channel soft-reset pulse generator for the TCU and its attached units (ctrl, mem IF, NoC IF, core).
//  - Each channel turns a 1-cycle request into a registered active-high reset pulse.
//  - Pulse length is programmable per channel.
//  - A power-on hold is applied after system reset.
//  - Per-channel completion strobes tell software/FSMs when a unit is out of reset.
// PARAMETERS
//  NUM_CH   4   number of independent reset channels (1..16)
//  CNT_W    8   width of per-channel length counter; max pulse = 2**CNT_W-1 cycles
//  POR_LEN  16  cycles all channels stay in reset after reset_i deasserts (1..2**CNT_W-1)
// PORTS
//  clk_i      in   1            single clock, all logic on rising edge
//  reset_i    in   1            synchronous reset, active-high
//  req_i      in   NUM_CH       per-channel reset request, 1-cycle pulse (level also accepted)
//  req_all_i  in   1            request on all channels at once (same as req_i = all ones)
//  len_i      in   NUM_CH*CNT_W per-channel pulse length; ch k uses len_i[k*CNT_W +: CNT_W]
//  rst_o      out  NUM_CH       per-channel reset, active-high, registered
//  busy_o     out  1            OR of rst_o, registered
//  done_o     out  NUM_CH       1-cycle strobe in the cycle rst_o[k] falls
// BEHAVIOUR
//  Reset:
//  - While reset_i=1: rst_o=all ones, busy_o=1, done_o=0.
//  - All counters load POR_LEN-1.
//  Power-on hold:
//  - The first cycle after reset_i falls counts as hold cycle 1.
//  - rst_o stays 1 for POR_LEN cycles after reset_i deasserts, then all channels release together.
//  - done_o=all ones for that single release cycle.
//  - Requests during the power-on hold follow the retrigger rule (see below).
//  Per channel, two states:
//  - IDLE (rst_o[k]=0) and ACTIVE (rst_o[k]=1); counter cnt[k] is CNT_W bits.
//  - Effective request: trig[k] = req_i[k] | req_all_i.
//  - IDLE & trig[k] at cycle t: go ACTIVE and load cnt = L-1, where L = len_i[k] sampled at t.
//    - L=0 is treated as L=1.
//    - rst_o[k]=1 for cycles t+1 .. t+L (exactly L cycles).
//  - ACTIVE & cnt!=0: cnt decrements by 1 each cycle.
//  - ACTIVE & cnt==0 & no retrigger: next cycle goes IDLE.
//    - rst_o[k]=0 and done_o[k]=1 in cycle t+L+1.
//  - Latency request->reset is 1 cycle; no combinational path from inputs to outputs.
//  - Channels are fully independent; simultaneous requests on any subset are all accepted in the same cycle.
//  - trig[k] in the same cycle ACTIVE ends (cnt==0):
//    - without EXTEND: the request is dropped and the channel goes IDLE.
//    - with EXTEND: the retrigger rule applies (reload; rst_o stays 1, no done_o).
//  - len_i changes while ACTIVE have no effect (length latched at trigger).
//  - busy_o = |rst_o, registered from the next-state value, so it is cycle-aligned with rst_o.
//  - reset_i mid-pulse: channel forced ACTIVE, cnt=POR_LEN-1, no done_o; power-on hold restarts.
//  - Counter never wraps: decrement only when cnt!=0.
// CONFIGURATION
//  TCU_RESET_EXTEND_EN defined:
//  - trig[k] while ACTIVE reloads cnt = max(L,1)-1 from current len_i.
//  - Pulse ends L cycles after the last request; no done_o until final release.
//  TCU_RESET_EXTEND_EN undefined:
//  - trig[k] while ACTIVE is ignored; pulse length is fixed by the first request.
// TESTING
//  T1 POR: POR_LEN=16, reset_i 1->0 at c0 -> rst_o=4'hF through c16, c17 rst_o=0, done_o=4'hF, busy_o=0
//  T2 single: req_i=4'b0010, len_i[1]=5 at c100 -> rst_o[1]=1 c101..c105, done_o[1] at c106, other ch 0
//  T3 len zero + all: req_all_i=1, len_i={8'd0,8'd3,8'd1,8'd2} -> ch3 1 cycle, ch2 3, ch1 1, ch0 2; done_o per ch at t+L+1
//  T4 retrigger: ch0 len=4 req at c0, again at c2 -> EXTEND: rst_o[0] c1..c6, done c7; no EXTEND: c1..c4, done c5
//  T5 reset mid-op: ch2 len=200 req at c0, reset_i=1 at c50 for 1 cycle -> rst_o=4'hF, no done_o, release at c67 (POR_LEN=16)
//  T6 max len: len_i[0]=8'hFF -> rst_o[0] high exactly 255 cycles, no wrap, single done_o strobe

Source files
------------

// File: rtl/tcu_reset_seq_if.sv
// Request/length/status bundle between a reset controller (master) and tcu_reset_seq (slave).
interface tcu_reset_seq_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic [NUM_CH-1:0]       req_i;
  logic                    req_all_i;
  logic [NUM_CH*CNT_W-1:0] len_i;
  logic [NUM_CH-1:0]       rst_o;
  logic                    busy_o;
  logic [NUM_CH-1:0]       done_o;

  modport master (
    output req_i, req_all_i, len_i,
    input  rst_o, busy_o, done_o
  );

  modport slave (
    input  req_i, req_all_i, len_i,
    output rst_o, busy_o, done_o
  );
endinterface

// File: rtl/tcu_reset_seq.sv
// Multi-channel soft-reset pulse generator with power-on hold and per-channel done strobes.
// Define TCU_RESET_EXTEND_EN to let a request during an active pulse restart its length.
module tcu_reset_seq #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int POR_LEN = 16
) (
  input logic          clk_i,
  input logic          reset_i,
  tcu_reset_seq_if.slave bus
);

  localparam logic [0:0]       ST_IDLE   = 1'b0;
  localparam logic [0:0]       ST_ACTIVE = 1'b1;
  localparam logic [CNT_W-1:0] POR_INIT  = CNT_W'(POR_LEN - 1);

  logic [NUM_CH-1:0] state;
  logic [NUM_CH-1:0] state_next;
  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [CNT_W-1:0]  cnt_next [NUM_CH];
  logic [CNT_W-1:0]  load_val [NUM_CH];
  logic [NUM_CH-1:0] trig;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] done_next;
  logic              busy;

  // A zero length is treated as a one-cycle pulse, so the reload value saturates at 0.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      trig[k] = bus.req_i[k] | bus.req_all_i;
      if (bus.len_i[k*CNT_W +: CNT_W] == '0)
        load_val[k] = '0;
      else
        load_val[k] = bus.len_i[k*CNT_W +: CNT_W] - CNT_W'(1);
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      state_next[k] = state[k];
      cnt_next[k]   = cnt[k];
      done_next[k]  = 1'b0;
      if (state[k] == ST_IDLE) begin
        if (trig[k]) begin
          state_next[k] = ST_ACTIVE;
          cnt_next[k]   = load_val[k];
        end
      end else if (cnt[k] != '0) begin
`ifdef TCU_RESET_EXTEND_EN
        if (trig[k])
          cnt_next[k] = load_val[k];
        else
          cnt_next[k] = cnt[k] - CNT_W'(1);
`else
        cnt_next[k] = cnt[k] - CNT_W'(1);
`endif
      end else begin
`ifdef TCU_RESET_EXTEND_EN
        if (trig[k]) begin
          cnt_next[k] = load_val[k];
        end else begin
          state_next[k] = ST_IDLE;
          done_next[k]  = 1'b1;
        end
`else
        state_next[k] = ST_IDLE;
        done_next[k]  = 1'b1;
`endif
      end
    end
  end

  // Reset parks every channel in ACTIVE with the power-on count, so the hold reuses the pulse logic.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= {NUM_CH{ST_ACTIVE}};
      done  <= '0;
      busy  <= 1'b1;
      for (int k = 0; k < NUM_CH; k++)
        cnt[k] <= POR_INIT;
    end else begin
      state <= state_next;
      done  <= done_next;
      busy  <= |state_next;
      for (int k = 0; k < NUM_CH; k++)
        cnt[k] <= cnt_next[k];
    end
  end

  assign bus.rst_o  = state;
  assign bus.busy_o = busy;
  assign bus.done_o = done;

endmodule

// File: tb/tb_tcu_reset_seq.sv
// Directed self-checking bench for tcu_reset_seq; expectations follow TCU_RESET_EXTEND_EN when defined.
module tb_tcu_reset_seq;

  logic clk;
  logic reset_i;
  int   compared;
  int   mismatched;

  tcu_reset_seq_if #(.NUM_CH(4), .CNT_W(8)) bus ();

  tcu_reset_seq #(.NUM_CH(4), .CNT_W(8), .POR_LEN(16)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_rst  [8];
  logic [3:0] exp_done [8];

  initial begin
    compared    = 0;
    mismatched  = 0;
    reset_i     = 1'b1;
    bus.req_i     = '0;
    bus.req_all_i = 1'b0;
    bus.len_i     = '0;

    // T1: reset state, then 16-cycle power-on hold counted from the first low cycle
    repeat (3) tick();
    check_output("T1 reset rst", bus.rst_o, 4'hF);
    check_output("T1 reset busy", bus.busy_o, 1'b1);
    check_output("T1 reset done", bus.done_o, 4'h0);
    reset_i = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      check_output("T1 hold rst", bus.rst_o, 4'hF);
      check_output("T1 hold done", bus.done_o, 4'h0);
      tick();
    end
    check_output("T1 release rst", bus.rst_o, 4'h0);
    check_output("T1 release done", bus.done_o, 4'hF);
    check_output("T1 release busy", bus.busy_o, 1'b0);
    tick();
    check_output("T1 after done", bus.done_o, 4'h0);
    repeat (3) tick();

    // T2: single channel, length 5; changing len mid-pulse must not matter
    bus.req_i = 4'b0010;
    bus.len_i = {8'd0, 8'd0, 8'd5, 8'd0};
    tick();
    bus.req_i = '0;
    check_output("T2 busy", bus.busy_o, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      check_output("T2 rst", bus.rst_o, 4'b0010);
      check_output("T2 done", bus.done_o, 4'b0000);
      if (i == 1) bus.len_i = {8'd0, 8'd0, 8'd20, 8'd0};
      tick();
    end
    check_output("T2 end rst", bus.rst_o, 4'b0000);
    check_output("T2 end done", bus.done_o, 4'b0010);
    check_output("T2 end busy", bus.busy_o, 1'b0);
    tick();
    check_output("T2 done strobe", bus.done_o, 4'b0000);
    repeat (2) tick();

    // T3: req_all with lengths {0,3,1,2}; zero acts as one
    bus.req_all_i = 1'b1;
    bus.len_i = {8'd0, 8'd3, 8'd1, 8'd2};
    tick();
    bus.req_all_i = 1'b0;
    check_output("T3 c1 rst", bus.rst_o, 4'hF);
    check_output("T3 c1 done", bus.done_o, 4'h0);
    tick();
    check_output("T3 c2 rst", bus.rst_o, 4'h5);
    check_output("T3 c2 done", bus.done_o, 4'hA);
    check_output("T3 c2 busy", bus.busy_o, 1'b1);
    tick();
    check_output("T3 c3 rst", bus.rst_o, 4'h4);
    check_output("T3 c3 done", bus.done_o, 4'h1);
    tick();
    check_output("T3 c4 rst", bus.rst_o, 4'h0);
    check_output("T3 c4 done", bus.done_o, 4'h4);
    check_output("T3 c4 busy", bus.busy_o, 1'b0);
    tick();
    check_output("T3 c5 done", bus.done_o, 4'h0);
    repeat (2) tick();

    // T4: ch0 len 4 requested at c0 and again at c2
`ifdef TCU_RESET_EXTEND_EN
    exp_rst  = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
    exp_done = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
`else
    exp_rst  = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    exp_done = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
`endif
    bus.req_i = 4'b0001;
    bus.len_i = {8'd0, 8'd0, 8'd0, 8'd4};
    tick();
    for (int c = 1; c <= 8; c++) begin
      bus.req_i = (c == 2) ? 4'b0001 : 4'b0000;
      check_output("T4 rst", bus.rst_o, exp_rst[c-1]);
      check_output("T4 done", bus.done_o, exp_done[c-1]);
      tick();
    end

    // T4b: ch1 len 2, request in the very cycle the count hits zero
`ifdef TCU_RESET_EXTEND_EN
    exp_rst  = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
    exp_done = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0};
`else
    exp_rst  = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    exp_done = '{4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
`endif
    bus.req_i = 4'b0010;
    bus.len_i = {8'd0, 8'd0, 8'd2, 8'd0};
    tick();
    for (int c = 1; c <= 8; c++) begin
      bus.req_i = (c == 2) ? 4'b0010 : 4'b0000;
      check_output("T4b rst", bus.rst_o, exp_rst[c-1]);
      check_output("T4b done", bus.done_o, exp_done[c-1]);
      tick();
    end

    // T5: ch2 len 200, reset pulse at c50 restarts the power-on hold
    bus.req_i = 4'b0100;
    bus.len_i = {8'd0, 8'd200, 8'd0, 8'd0};
    tick();
    bus.req_i = '0;
    for (int c = 1; c <= 49; c++) begin
      check_output("T5 pulse rst", bus.rst_o, 4'b0100);
      tick();
    end
    check_output("T5 c50 rst", bus.rst_o, 4'b0100);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    for (int c = 51; c <= 66; c++) begin
      check_output("T5 hold rst", bus.rst_o, 4'hF);
      check_output("T5 hold done", bus.done_o, 4'h0);
      check_output("T5 hold busy", bus.busy_o, 1'b1);
      tick();
    end
    check_output("T5 c67 rst", bus.rst_o, 4'h0);
    check_output("T5 c67 done", bus.done_o, 4'hF);
    tick();
    check_output("T5 c68 done", bus.done_o, 4'h0);
    repeat (2) tick();

    // T6: maximum length 255 on ch0, no wrap and a single done strobe
    bus.req_i = 4'b0001;
    bus.len_i = {8'd0, 8'd0, 8'd0, 8'hFF};
    tick();
    bus.req_i = '0;
    for (int c = 1; c <= 255; c++) begin
      check_output("T6 rst", bus.rst_o, 4'b0001);
      check_output("T6 done", bus.done_o, 4'b0000);
      tick();
    end
    check_output("T6 end rst", bus.rst_o, 4'b0000);
    check_output("T6 end done", bus.done_o, 4'b0001);
    for (int c = 257; c <= 260; c++) begin
      tick();
      check_output("T6 post rst", bus.rst_o, 4'b0000);
      check_output("T6 post done", bus.done_o, 4'b0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
